// File: rtl/das_beamformer_param.sv
// Parametrised delay-and-sum beamformer: per-mic circular delay line, mask,
// saturating sum. Steering delays are double-buffered (shadow -> active on commit).
module das_beamformer_param #(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned NUM_MICS  = 9,
    parameter int unsigned MAX_DELAY = 128,
    parameter int unsigned DELAY_W   = $clog2(MAX_DELAY),
    parameter int unsigned MIC_IDX_W = $clog2(NUM_MICS),
    parameter int unsigned SUM_WIDTH = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_in,
    input  logic                          dly_wr_en,
    input  logic [MIC_IDX_W-1:0]          dly_wr_mic,
    input  logic [DELAY_W-1:0]            dly_wr_val,
    input  logic                          dly_commit,
    input  logic [NUM_MICS-1:0]           mic_mask,
    output logic                          sum_valid,
    output logic [SUM_WIDTH-1:0]          sum_out,
    output logic                          sat_flag,
    output logic                          commit_pending,
    output logic                          dly_err
);

    localparam int unsigned FULL_W = BIT_WIDTH + $clog2(NUM_MICS);
    localparam int unsigned EXT_W  = (SUM_WIDTH > FULL_W) ? SUM_WIDTH : FULL_W;
    localparam int unsigned HI_W   = EXT_W - SUM_WIDTH + 1;
    localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(MAX_DELAY - 1);

    logic [BIT_WIDTH-1:0]    mem [NUM_MICS][MAX_DELAY];
    logic [DELAY_W-1:0]      wptr;
    logic [DELAY_W-1:0]      fill_cnt;
    logic [DELAY_W-1:0]      shadow_dly [NUM_MICS];
    logic [DELAY_W-1:0]      active_dly [NUM_MICS];
    logic [BIT_WIDTH-1:0]    tap [NUM_MICS];
    logic signed [EXT_W-1:0] s1_val [NUM_MICS];
    logic                    s1_valid;
    logic signed [EXT_W-1:0] sum_full;
    logic [HI_W-1:0]         hi_bits;
    logic [SUM_WIDTH-1:0]    sum_sat;
    logic                    sat_now;
    logic                    swap;
    logic                    wr_ok;

    assign swap  = sample_valid & (commit_pending | dly_commit);
    assign wr_ok = dly_wr_en & (32'(dly_wr_mic) < NUM_MICS);

    // Buffer RAM carries no reset; fill_cnt gating hides stale entries.
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            for (int k = 0; k < NUM_MICS; k++) begin
                mem[k][wptr] <= pcm_data_in[k*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // Tap select against pre-increment wptr/fill_cnt.
    always_comb begin
        logic [DELAY_W-1:0] rd_idx;
        rd_idx = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            tap[k] = '0;
            rd_idx = wptr - active_dly[k];
            if (active_dly[k] == '0) begin
                tap[k] = pcm_data_in[k*BIT_WIDTH +: BIT_WIDTH];
            end else if (active_dly[k] <= fill_cnt) begin
                tap[k] = mem[k][rd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr           <= '0;
            fill_cnt       <= '0;
            commit_pending <= 1'b0;
            dly_err        <= 1'b0;
            for (int k = 0; k < NUM_MICS; k++) begin
                shadow_dly[k] <= '0;
                active_dly[k] <= '0;
            end
        end else begin
            dly_err <= dly_wr_en & ~wr_ok;
            if (wr_ok) begin
                shadow_dly[dly_wr_mic] <= dly_wr_val;
            end
            if (swap) begin
                active_dly     <= shadow_dly;
                commit_pending <= 1'b0;
            end else if (dly_commit) begin
                commit_pending <= 1'b1;
            end
            if (sample_valid) begin
                wptr <= wptr + DELAY_W'(1);
                if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + DELAY_W'(1);
                end
            end
        end
    end

    // Stage 1: sign-extend and mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < NUM_MICS; k++) begin
                s1_val[k] <= '0;
            end
        end else begin
            s1_valid <= sample_valid;
            if (sample_valid) begin
                for (int k = 0; k < NUM_MICS; k++) begin
                    s1_val[k] <= mic_mask[k] ? EXT_W'($signed(tap[k])) : '0;
                end
            end
        end
    end

    // Full-precision sum with clamp into SUM_WIDTH.
    always_comb begin
        sum_full = '0;
        for (int k = 0; k < NUM_MICS; k++) begin
            sum_full = sum_full + s1_val[k];
        end
        hi_bits = sum_full[EXT_W-1 -: HI_W];
        sum_sat = sum_full[SUM_WIDTH-1:0];
        sat_now = 1'b0;
        if (!(hi_bits == '0 || hi_bits == '1)) begin
            sat_now = 1'b1;
            sum_sat = sum_full[EXT_W-1] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                        : {1'b0, {(SUM_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid <= 1'b0;
            sum_out   <= '0;
            sat_flag  <= 1'b0;
        end else begin
            sum_valid <= s1_valid;
            if (s1_valid) begin
                sum_out  <= sum_sat;
                sat_flag <= sat_now;
            end
        end
    end

endmodule
